// File: rtl/arb_mux2.sv
// arb_mux2: two-source round-robin front end for the 2:1 byte mux datapath.
// Accepts words from sources A and B over valid/ready handshakes. On a tie it
// alternates fairly between them. The winner is held in one output register,
// together with the select value that the downstream mux stage consumes.
// Per-source transfer counters are provided for debug visibility.
module arb_mux2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_data_o,
    output logic              sel_o,
    input  logic              y_ready_i,
    output logic [CNT_W-1:0]  cnt_a_o,
    output logic [CNT_W-1:0]  cnt_b_o
);

    // Source identifiers share the polarity of the downstream mux select.
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_sel_q,   out_sel_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_a_q,     cnt_a_d;
    logic [CNT_W-1:0]  cnt_b_q,     cnt_b_d;

    logic load_en_s;
    logic grant_s;
    logic grant_id_s;

    // Arbitration: decide whether a word can be taken this cycle and from whom.
    always_comb begin
        load_en_s  = ~out_valid_q | y_ready_i;
        grant_s    = 1'b0;
        grant_id_s = SRC_A;
        if (load_en_s && !reset) begin
            case ({a_valid_i, b_valid_i})
                2'b10: begin
                    grant_s    = 1'b1;
                    grant_id_s = SRC_A;
                end
                2'b01: begin
                    grant_s    = 1'b1;
                    grant_id_s = SRC_B;
                end
                2'b11: begin
                    // On a tie the source that did not win last time is served.
                    grant_s    = 1'b1;
                    grant_id_s = ~last_grant_q;
                end
                default: begin
                    grant_s    = 1'b0;
                    grant_id_s = SRC_A;
                end
            endcase
        end else begin
            grant_s    = 1'b0;
            grant_id_s = SRC_A;
        end
    end

    // Handshake outputs: a ready can only go high for the granted source.
    always_comb begin
        a_ready_o = grant_s & (grant_id_s == SRC_A);
        b_ready_o = grant_s & (grant_id_s == SRC_B);
    end

    // Next-state: load on grant, drop valid on a bare drain, otherwise hold.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        last_grant_d = last_grant_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        if (grant_s) begin
            // A drain in the same cycle is covered: the new word replaces the old.
            out_valid_d  = 1'b1;
            out_data_d   = (grant_id_s == SRC_B) ? b_data_i : a_data_i;
            out_sel_d    = grant_id_s;
            last_grant_d = grant_id_s;
            if (grant_id_s == SRC_B) begin
                cnt_b_d = cnt_b_q + CNT_W'(1);
            end else begin
                cnt_a_d = cnt_a_q + CNT_W'(1);
            end
        end else if (out_valid_q && y_ready_i) begin
            // Data and select keep their last values after a drain.
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State register with synchronous reset; last_grant resets to B so A wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {DATA_W{1'b0}};
            out_sel_q    <= SRC_A;
            last_grant_q <= SRC_B;
            cnt_a_q      <= {CNT_W{1'b0}};
            cnt_b_q      <= {CNT_W{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            last_grant_q <= last_grant_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
        end
    end

    // Registered outputs straight from the state flops.
    always_comb begin
        y_valid_o = out_valid_q;
        y_data_o  = out_data_q;
        sel_o     = out_sel_q;
        cnt_a_o   = cnt_a_q;
        cnt_b_o   = cnt_b_q;
    end

endmodule

// File: tb/tb_arb_mux2.sv
// Directed testbench for arb_mux2 with hand-computed expected values.
module tb_arb_mux2;

    logic       clk;
    logic       reset;
    logic       a_valid_i;
    logic [7:0] a_data_i;
    logic       a_ready_o;
    logic       b_valid_i;
    logic [7:0] b_data_i;
    logic       b_ready_o;
    logic       y_valid_o;
    logic [7:0] y_data_o;
    logic       sel_o;
    logic       y_ready_i;
    logic [7:0] cnt_a_o;
    logic [7:0] cnt_b_o;

    int n_checks;
    int n_errors;

    arb_mux2 #(.DATA_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid_i (a_valid_i),
        .a_data_i  (a_data_i),
        .a_ready_o (a_ready_o),
        .b_valid_i (b_valid_i),
        .b_data_i  (b_data_i),
        .b_ready_o (b_ready_o),
        .y_valid_o (y_valid_o),
        .y_data_o  (y_data_o),
        .sel_o     (sel_o),
        .y_ready_i (y_ready_i),
        .cnt_a_o   (cnt_a_o),
        .cnt_b_o   (cnt_b_o)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check both readies away from the active edge.
    task automatic check_ready(input string tag, input logic exp_a, input logic exp_b);
        @(negedge clk);
        check({tag, ".a_ready"}, 32'(a_ready_o), 32'(exp_a));
        check({tag, ".b_ready"}, 32'(b_ready_o), 32'(exp_b));
    endtask

    // Check the registered output word.
    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic s);
        check({tag, ".y_valid"}, 32'(y_valid_o), 32'(v));
        check({tag, ".y_data"},  32'(y_data_o),  32'(d));
        check({tag, ".sel"},     32'(sel_o),     32'(s));
    endtask

    // Check both transfer counters.
    task automatic check_cnt(input string tag, input logic [7:0] ca, input logic [7:0] cb);
        check({tag, ".cnt_a"}, 32'(cnt_a_o), 32'(ca));
        check({tag, ".cnt_b"}, 32'(cnt_b_o), 32'(cb));
    endtask

    logic [7:0] exp_cnt_a;

    // Directed stimulus sequence.
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        a_valid_i = 1'b1;
        a_data_i  = 8'hE1;
        b_valid_i = 1'b1;
        b_data_i  = 8'hE2;
        y_ready_i = 1'b1;

        // Reset with both sources valid: no readies for two cycles.
        check_ready("rst0", 1'b0, 1'b0);
        tick();
        check_ready("rst1", 1'b0, 1'b0);
        tick();
        reset     = 1'b0;
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        check_out("idle", 1'b0, 8'h00, 1'b0);
        check_cnt("idle", 8'd0, 8'd0);

        // Contention: A wins the first tie, then strict alternation.
        a_valid_i = 1'b1; a_data_i = 8'h11;
        b_valid_i = 1'b1; b_data_i = 8'h22;
        check_ready("con0", 1'b1, 1'b0); tick(); check_out("con0", 1'b1, 8'h11, 1'b0);
        check_ready("con1", 1'b0, 1'b1); tick(); check_out("con1", 1'b1, 8'h22, 1'b1);
        check_ready("con2", 1'b1, 1'b0); tick(); check_out("con2", 1'b1, 8'h11, 1'b0);
        check_ready("con3", 1'b0, 1'b1); tick(); check_out("con3", 1'b1, 8'h22, 1'b1);
        check_cnt("con", 8'd2, 8'd2);

        // Drain with no new word.
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        tick();
        check_out("drain0", 1'b0, 8'h22, 1'b1);

        // Single source A.
        a_valid_i = 1'b1; a_data_i = 8'h3C;
        check_ready("single", 1'b1, 1'b0);
        tick();
        check_out("single", 1'b1, 8'h3C, 1'b0);
        check_cnt("single", 8'd3, 8'd2);

        // Drain and load together: 0x5A replaces 0x3C with no bubble.
        a_data_i = 8'h5A;
        tick();
        check_out("load5a", 1'b1, 8'h5A, 1'b0);

        // Backpressure: B waits while 0x5A is held.
        a_valid_i = 1'b0;
        b_valid_i = 1'b1; b_data_i = 8'h77;
        y_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_ready("bp", 1'b0, 1'b0);
            tick();
            check_out("bp", 1'b1, 8'h5A, 1'b0);
            check_cnt("bp", 8'd4, 8'd2);
        end
        y_ready_i = 1'b1;
        check_ready("bprel", 1'b0, 1'b1);
        tick();
        check_out("bprel", 1'b1, 8'h77, 1'b1);
        check_cnt("bprel", 8'd4, 8'd3);

        // Bare drain keeps data and select.
        b_valid_i = 1'b0;
        tick();
        check_out("drain1", 1'b0, 8'h77, 1'b1);

        // Counter wrap: 256 back-to-back A transfers.
        exp_cnt_a = 8'd4;
        a_valid_i = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a_data_i  = 8'(i);
            exp_cnt_a = exp_cnt_a + 8'd1;
            tick();
            check("wrap.cnt_a", 32'(cnt_a_o), 32'(exp_cnt_a));
        end
        check_out("wrap", 1'b1, 8'hFF, 1'b0);
        check_cnt("wrap", 8'd4, 8'd3);

        // Mid-stream reset under contention; last grant was A so B wins this tie.
        a_data_i  = 8'hAA;
        b_valid_i = 1'b1; b_data_i = 8'hBB;
        tick();
        check_out("pre_rst", 1'b1, 8'hBB, 1'b1);
        reset = 1'b1;
        check_ready("midrst", 1'b0, 1'b0);
        tick();
        check_out("midrst", 1'b0, 8'h00, 1'b0);
        check_cnt("midrst", 8'd0, 8'd0);
        reset = 1'b0;
        check_ready("postrst", 1'b1, 1'b0);
        tick();
        check_out("postrst", 1'b1, 8'hAA, 1'b0);
        check_cnt("postrst", 8'd1, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
